multdiv_sequencer: RTL and testbench

Multi-cycle controller that shares the single multiply/divide unit with the 5-stage pipeline. It detects a mul/div instruction in the execute (D/X) stage, latches its operands and destination register, and pulses the unit's start control. It stalls PC, F/D and D/X until the result is ready, then presents the result for one cycle so it can be injected into the X/M latch.

---
 rtl/multdiv_sequencer.sv | 148 ++++++++++++++
 tb/tb_multdiv_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Sequences one mul/div through the shared multiply/divide unit and stalls the front of the pipeline meanwhile.
// Optional BUSY watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_sequencer #(
  parameter int WIDTH      = 32,
  parameter int RD_W       = 5,
  parameter int MAX_CYCLES = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dx_is_md,
  input  logic             dx_is_div,
  input  logic [RD_W-1:0]  dx_rd,
  input  logic [WIDTH-1:0] dx_opA,
  input  logic [WIDTH-1:0] dx_opB,
  input  logic             abort,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic [WIDTH-1:0] md_opA,
  output logic [WIDTH-1:0] md_opB,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [RD_W-1:0]  result_rd,
  output logic             exception
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  // The watchdog counter is 6 bits wide, so the limit must fit in it.
  if (MAX_CYCLES < 1 || MAX_CYCLES > 63) begin : g_cfg_check
    $error("multdiv_sequencer: MAX_CYCLES must be in 1..63");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  md_opA_q, md_opA_d;
  logic [WIDTH-1:0]  md_opB_q, md_opB_d;
  logic              is_div_q, is_div_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [RD_W-1:0]   result_rd_q, result_rd_d;
  logic              exception_q, exception_d;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [5:0] LIMIT = 6'(MAX_CYCLES - 1);
  logic [5:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    md_opA_d    = md_opA_q;
    md_opB_d    = md_opB_q;
    is_div_d    = is_div_q;
    rd_d        = rd_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    exception_d = exception_q;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (dx_is_md && !abort) begin
          md_opA_d = dx_opA;
          md_opB_d = dx_opB;
          is_div_d = dx_is_div;
          rd_d     = dx_rd;
          state_d  = START;
        end
      end
      START: begin
        state_d = abort ? IDLE : BUSY;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (md_resultRDY) begin
          result_d    = md_result;
          exception_d = md_exception;
          result_rd_d = rd_q;
          state_d     = DONE;
        end
`ifdef MULTDIV_TIMEOUT_EN
        // A result arriving on the limit cycle takes priority over the timeout.
        else if (cnt_q == LIMIT) begin
          result_d    = '0;
          exception_d = 1'b1;
          result_rd_d = rd_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      md_opA_q    <= '0;
      md_opB_q    <= '0;
      is_div_q    <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      result_rd_q <= '0;
      exception_q <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      md_opA_q    <= md_opA_d;
      md_opB_q    <= md_opB_d;
      is_div_q    <= is_div_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
      exception_q <= exception_d;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Stall covers the detect cycle too, so D/X cannot slip past before START.
  assign stall        = ((state_q == IDLE && dx_is_md) || state_q == START || state_q == BUSY) && !abort;
  assign md_ctrl_mult = (state_q == START) && !is_div_q;
  assign md_ctrl_div  = (state_q == START) && is_div_q;
  assign done         = (state_q == DONE);
  assign md_opA       = md_opA_q;
  assign md_opB       = md_opB_q;
  assign result       = result_q;
  assign result_rd    = result_rd_q;
  assign exception    = exception_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer; plays the role of the mul/div unit and the pipeline.
// Exercises the watchdog when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_sequencer;
  localparam int W    = 32;
  localparam int R    = 5;
  localparam int MAXC = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         dx_is_md, dx_is_div, abort;
  logic [R-1:0] dx_rd;
  logic [W-1:0] dx_opA, dx_opB;
  logic         md_ctrl_mult, md_ctrl_div;
  logic [W-1:0] md_opA, md_opB, md_result;
  logic         md_exception, md_resultRDY;
  logic         stall, done, exception;
  logic [W-1:0] result;
  logic [R-1:0] result_rd;

  int total  = 0;
  int passed = 0;
  logic [W-1:0] last_result;
  logic [R-1:0] last_rd;
  logic         last_exc;

  multdiv_sequencer #(.WIDTH(W), .RD_W(R), .MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset), .dx_is_md(dx_is_md), .dx_is_div(dx_is_div), .dx_rd(dx_rd),
    .dx_opA(dx_opA), .dx_opB(dx_opB), .abort(abort), .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div(md_ctrl_div), .md_opA(md_opA), .md_opB(md_opB), .md_result(md_result),
    .md_exception(md_exception), .md_resultRDY(md_resultRDY), .stall(stall), .done(done),
    .result(result), .result_rd(result_rd), .exception(exception)
  );

  always #5 clock = ~clock;

  // Behaviour of the shared arithmetic unit: low word of product, unsigned quotient, 0 on divide-by-zero.
  function automatic logic [W-1:0] unit_value(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    if (is_div) return (b == '0) ? '0 : a / b;
    return a * b;
  endfunction

  function automatic logic unit_exc(input bit is_div, input logic [W-1:0] b);
    return is_div && (b == '0);
  endfunction

  // Detect cycle then START cycle; leaves the bench in the START cycle.
  task automatic launch(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b, input logic [R-1:0] rd);
    @(posedge clock); #1;
    abort = 1'b0; dx_is_md = 1'b1; dx_is_div = is_div; dx_rd = rd; dx_opA = a; dx_opB = b; #1;
    total++; if (stall !== 1'b1) $display("FAIL detect_stall: got %b want 1", stall); else passed++;
    total++; if ({md_ctrl_mult, md_ctrl_div, done} !== 3'b000) $display("FAIL detect_quiet: got %b want 000", {md_ctrl_mult, md_ctrl_div, done}); else passed++;
    @(posedge clock); #1;
    total++; if ({md_ctrl_mult, md_ctrl_div} !== {~is_div, is_div}) $display("FAIL start_pulse: got %b want %b", {md_ctrl_mult, md_ctrl_div}, {~is_div, is_div}); else passed++;
    total++; if (stall !== 1'b1) $display("FAIL start_stall: got %b want 1", stall); else passed++;
    total++; if ({md_opA, md_opB} !== {a, b}) $display("FAIL start_operands: got %h/%h want %h/%h", md_opA, md_opB, a, b); else passed++;
  endtask

  task automatic do_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b, input logic [R-1:0] rd,
                       input int lat, input bit abort_in_done);
    logic [W-1:0] exp_res;
    logic         exp_exc;
    launch(is_div, a, b, rd);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock); #1;
      total++; if ({stall, md_ctrl_mult, md_ctrl_div, done} !== 4'b1000) $display("FAIL busy_wait: got %b want 1000", {stall, md_ctrl_mult, md_ctrl_div, done}); else passed++;
      if (k == lat) begin
        md_resultRDY = 1'b1;
        md_result    = unit_value(is_div, md_opA, md_opB);
        md_exception = unit_exc(is_div, md_opB);
      end
    end
    @(posedge clock); #1;
    md_resultRDY = 1'b0; md_result = $urandom; md_exception = 1'b1;
    if (abort_in_done) abort = 1'b1;
    #1;
    exp_res = unit_value(is_div, a, b);
    exp_exc = unit_exc(is_div, b);
    total++; if ({done, stall} !== 2'b10) $display("FAIL done_cycle: got done/stall %b want 10", {done, stall}); else passed++;
    total++; if (result !== exp_res) $display("FAIL result: got %h want %h", result, exp_res); else passed++;
    total++; if (result_rd !== rd) $display("FAIL result_rd: got %0d want %0d", result_rd, rd); else passed++;
    total++; if (exception !== exp_exc) $display("FAIL exception: got %b want %b", exception, exp_exc); else passed++;
    $display("op %s a=%h b=%h rd=%0d lat=%0d -> result=%h rd=%0d exc=%b", is_div ? "div" : "mul", a, b, rd, lat, result, result_rd, exception);
    last_result = exp_res; last_rd = rd; last_exc = exp_exc;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      dx_is_md = 1'b0; abort = 1'b0; md_resultRDY = 1'b0; #1;
      total++; if ({stall, md_ctrl_mult, md_ctrl_div, done} !== 4'b0000) $display("FAIL idle_quiet: got %b want 0000", {stall, md_ctrl_mult, md_ctrl_div, done}); else passed++;
      total++; if ({result, result_rd, exception} !== {last_result, last_rd, last_exc}) $display("FAIL result_hold: got %h/%0d/%b want %h/%0d/%b", result, result_rd, exception, last_result, last_rd, last_exc); else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dx_is_md = 1'b0; dx_is_div = 1'b0; dx_rd = '0; dx_opA = '0; dx_opB = '0; abort = 1'b0;
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    repeat (2) @(posedge clock); #1;
    total++; if ({stall, done, md_ctrl_mult, md_ctrl_div, exception} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {stall, done, md_ctrl_mult, md_ctrl_div, exception}); else passed++;
    total++; if ({md_opA, md_opB, result, result_rd} !== '0) $display("FAIL reset_data: got %h/%h/%h/%0d want all 0", md_opA, md_opB, result, result_rd); else passed++;
    reset = 1'b0;
    last_result = '0; last_rd = '0; last_exc = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_mul_basic();
    do_op(1'b0, 32'd6, 32'd7, 5'd5, 4, 1'b0);
    idle_cycles(2);
  endtask

  task automatic test_div();
    do_op(1'b1, 32'd7, 32'd0, 5'd9, 3, 1'b0);
    idle_cycles(1);
    do_op(1'b1, 32'd100, 32'd7, 5'd31, 1, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 32'd3, 32'd4, 5'd2, 2, 1'b0);
    do_op(1'b0, 32'd5, 32'd5, 5'd3, 1, 1'b0);
    idle_cycles(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      bit           d;
      logic [W-1:0] a, b;
      d = 1'(($urandom & 32'd1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      do_op(d, a, b, 5'($urandom), $urandom_range(1, 6), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(1);
  endtask

  task automatic test_abort();
    launch(1'b0, 32'd11, 32'd13, 5'd7);
    repeat (2) begin @(posedge clock); #1; end
    abort = 1'b1; #1;
    total++; if ({stall, done} !== 2'b00) $display("FAIL abort_busy_stall: got %b want 00", {stall, done}); else passed++;
    @(posedge clock); #1;
    abort = 1'b0; dx_is_md = 1'b0; md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF; #1;
    total++; if ({stall, done} !== 2'b00) $display("FAIL abort_late_rdy: got %b want 00", {stall, done}); else passed++;
    $display("abort in BUSY, late rdy offered");
    idle_cycles(3);
    launch(1'b1, 32'd50, 32'd5, 5'd4);
    abort = 1'b1; #1;
    total++; if (stall !== 1'b0) $display("FAIL abort_start_stall: got %b want 0", stall); else passed++;
    $display("abort in START");
    idle_cycles(3);
    do_op(1'b0, 32'd9, 32'd9, 5'd12, 2, 1'b1);
    idle_cycles(1);
  endtask

  task automatic test_async_reset();
    launch(1'b0, 32'd21, 32'd2, 5'd17);
    repeat (2) begin @(posedge clock); #1; end
    #2; reset = 1'b1; dx_is_md = 1'b0; #1;
    total++; if ({stall, done, md_ctrl_mult, md_ctrl_div, exception} !== 5'b0) $display("FAIL async_reset_ctrl: got %b want 00000", {stall, done, md_ctrl_mult, md_ctrl_div, exception}); else passed++;
    total++; if ({md_opA, md_opB, result, result_rd} !== '0) $display("FAIL async_reset_data: got %h/%h/%h/%0d want all 0", md_opA, md_opB, result, result_rd); else passed++;
    $display("async reset mid-BUSY");
    @(posedge clock); #1;
    reset = 1'b0; md_resultRDY = 1'b1; md_result = 32'h1234_5678;
    last_result = '0; last_rd = '0; last_exc = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_timeout();
`ifdef MULTDIV_TIMEOUT_EN
    int busy_n;
    bit seen;
    busy_n = 0; seen = 1'b0;
    launch(1'b1, 32'd77, 32'd3, 5'd22);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1; else busy_n++;
    end
    total++; if (!seen) $display("FAIL timeout_bound: got no done want done"); else passed++;
    total++; if (busy_n != MAXC) $display("FAIL timeout_cycles: got %0d want %0d", busy_n, MAXC); else passed++;
    total++; if ({result, exception, result_rd} !== {32'd0, 1'b1, 5'd22}) $display("FAIL timeout_result: got %h/%b/%0d want 0/1/22", result, exception, result_rd); else passed++;
    $display("timeout after %0d BUSY cycles", busy_n);
    last_result = '0; last_rd = 5'd22; last_exc = 1'b1;
    idle_cycles(2);
`else
    int high_n;
    high_n = 0;
    launch(1'b0, 32'd77, 32'd3, 5'd22);
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (stall === 1'b1 && done === 1'b0) high_n++;
    end
    total++; if (high_n != 100) $display("FAIL no_timeout_stall: got %0d stalled cycles want 100", high_n); else passed++;
    $display("no timeout: stall held for %0d cycles", high_n);
    abort = 1'b1;
    idle_cycles(2);
`endif
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div();
    test_back_to_back();
    test_random();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
